// File: rtl/uart_tx_fifo_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_pkg
// Shared UART definitions: serialiser state encoding, parity mode constants,
// divisor rounding and parity helper. Also intended for the matching receiver.
// ----------------------------------------------------------------------------
package uart_tx_fifo_pkg;

  // Serialiser states, encoded explicitly so a receiver can share them.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Parity modes.
  localparam int UART_PAR_NONE = 32'sd0;
  localparam int UART_PAR_ODD  = 32'sd1;
  localparam int UART_PAR_EVEN = 32'sd2;

  // Widest legal frame payload; the parity helper works on this width.
  localparam int UART_DATA_W_MAX = 32'sd9;

  // Clocks per bit, rounded to nearest.
  function automatic int uart_div(input int clk_frq, input int baud);
    uart_div = (clk_frq + (baud / 32'sd2)) / baud;
  endfunction

  // Parity bit for a zero-extended word; zero padding does not change the XOR.
  function automatic logic uart_parity_bit(input logic [UART_DATA_W_MAX-1:0] data,
                                           input int mode);
    logic w_xor;
    logic w_bit;
    w_xor = ^data;
    case (mode)
      UART_PAR_ODD:  w_bit = ~w_xor;
      UART_PAR_EVEN: w_bit = w_xor;
      default:       w_bit = 1'b0;
    endcase
    uart_parity_bit = w_bit;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with synchronous active-high reset and occupancy count.
// The head word is presented straight out of the register array, so it is
// valid the cycle after it was written and can be consumed on the pop edge.
// Ports:
//   i_clk      clock
//   i_reset    synchronous reset, clears pointers and count
//   i_push     write request (ignored when full)
//   i_wr_data  word to write
//   i_pop      read request (ignored when empty)
//   o_rd_data  head word
//   o_count    words stored, 0..P_DEPTH
//   o_full     count == P_DEPTH
//   o_empty    count == 0
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int P_DATA_W = 8,
  parameter int P_DEPTH  = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_push,
  input  logic [P_DATA_W-1:0]          i_wr_data,
  input  logic                         i_pop,
  output logic [P_DATA_W-1:0]          o_rd_data,
  output logic [$clog2(P_DEPTH):0]     o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int L_PTR_W = $clog2(P_DEPTH);
  localparam int L_CNT_W = L_PTR_W + 1;
  localparam logic [L_CNT_W-1:0] L_FULL_CNT = L_CNT_W'(P_DEPTH);

  // Pointer wrap relies on a power-of-two depth.
  if ((P_DEPTH < 2) || ((P_DEPTH & (P_DEPTH - 1)) != 0)) begin : g_depth_err
    $error("sync_fifo: P_DEPTH must be a power of 2 and >= 2");
  end

  logic [P_DATA_W-1:0] r_mem [P_DEPTH];
  logic [L_PTR_W-1:0]  r_wr_ptr;
  logic [L_PTR_W-1:0]  r_rd_ptr;
  logic [L_CNT_W-1:0]  r_count;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_full    = (r_count == L_FULL_CNT);
  assign o_empty   = (r_count == {L_CNT_W{1'b0}});
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage array; contents are don't-care after reset since pointers clear.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= {L_PTR_W{1'b0}};
      r_rd_ptr <= {L_PTR_W{1'b0}};
      r_count  <= {L_CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered UART transmitter. Words enter through a VALID/READY port, are
// queued in sync_fifo and sent back-to-back, LSB first, with configurable
// data width, parity and stop bits.
// Ports:
//   i_clk       clock, rising edge
//   i_reset     synchronous reset, active-high, highest priority
//   i_wr_data   word to send
//   i_wr_valid  i_wr_data valid
//   o_wr_ready  FIFO can accept (not full, no write-through when full)
//   o_uart_tx   serial line, idle high, registered
//   o_busy      frame in progress or FIFO non-empty, registered
//   o_fifo_cnt  words queued
// ----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int P_CLK_FRQ    = 48_000_000,
  parameter int P_BAURATE    = 9600,
  parameter int P_DATA_W     = 8,
  parameter int P_PARITY     = 0,
  parameter int P_STOP       = 1,
  parameter int P_FIFO_DEPTH = 16
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [P_DATA_W-1:0]             i_wr_data,
  input  logic                            i_wr_valid,
  output logic                            o_wr_ready,
  output logic                            o_uart_tx,
  output logic                            o_busy,
  output logic [$clog2(P_FIFO_DEPTH):0]   o_fifo_cnt
);

  localparam int L_DIV    = uart_div(P_CLK_FRQ, P_BAURATE);
  localparam int L_BAUD_W = (L_DIV > 1) ? $clog2(L_DIV) : 1;
  localparam int L_CNT_W  = $clog2(P_FIFO_DEPTH) + 1;
  localparam logic [L_BAUD_W-1:0] L_BAUD_LAST = L_BAUD_W'(L_DIV - 1);
  localparam logic [3:0]          L_DATA_LAST = 4'(P_DATA_W - 1);
  localparam logic [3:0]          L_STOP_LAST = 4'(P_STOP - 1);

  // Reject unsupported configurations at elaboration.
  if ((P_DATA_W < 5) || (P_DATA_W > UART_DATA_W_MAX) ||
      (P_PARITY < UART_PAR_NONE) || (P_PARITY > UART_PAR_EVEN) ||
      (P_STOP < 1) || (P_STOP > 2) || (L_DIV < 2) ||
      (P_FIFO_DEPTH < 2) || ((P_FIFO_DEPTH & (P_FIFO_DEPTH - 1)) != 0)) begin : g_param_err
    $error("uart_tx_fifo: illegal parameter set");
  end

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [P_DATA_W-1:0]   w_head;
  logic [L_CNT_W-1:0]    w_count;
  logic                  w_baud_last;

  uart_state_e           r_state;
  logic [L_BAUD_W-1:0]   r_baud;
  logic [3:0]            r_bit_cnt;
  logic [P_DATA_W-1:0]   r_shift;
  logic                  r_par;
  logic                  r_tx;
  logic                  r_busy;

  // Ready comes straight from the count, so a full FIFO refuses even when
  // a pop happens on the same edge.
  assign o_wr_ready  = ~w_full;
  assign w_push      = i_wr_valid & ~w_full;
  assign w_baud_last = (r_baud == L_BAUD_LAST);
  assign o_uart_tx   = r_tx;
  assign o_busy      = r_busy;
  assign o_fifo_cnt  = w_count;

  sync_fifo #(
    .P_DATA_W (P_DATA_W),
    .P_DEPTH  (P_FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_push    (w_push),
    .i_wr_data (i_wr_data),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Pop the head when idle, or on the very last stop clock so the next
  // start bit follows with no idle gap.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
        end else begin
          w_pop = 1'b0;
        end
      end
      ST_STOP: begin
        if (w_baud_last && (r_bit_cnt == L_STOP_LAST) && !w_empty) begin
          w_pop = 1'b1;
        end else begin
          w_pop = 1'b0;
        end
      end
      default: w_pop = 1'b0;
    endcase
  end

  // Serialiser FSM with baud counter; the line level is registered and set
  // on the edge that enters each bit, so every bit lasts exactly L_DIV clocks.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_baud    <= {L_BAUD_W{1'b0}};
      r_bit_cnt <= 4'd0;
      r_shift   <= {P_DATA_W{1'b0}};
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_busy <= (r_state != ST_IDLE) || !w_empty;
      case (r_state)
        ST_IDLE: begin
          r_baud    <= {L_BAUD_W{1'b0}};
          r_bit_cnt <= 4'd0;
          if (w_pop) begin
            r_shift <= w_head;
            r_par   <= uart_parity_bit(UART_DATA_W_MAX'(w_head), P_PARITY);
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end else begin
            r_tx <= 1'b1;
          end
        end
        ST_START: begin
          if (w_baud_last) begin
            r_baud    <= {L_BAUD_W{1'b0}};
            r_bit_cnt <= 4'd0;
            r_tx      <= r_shift[0];
            r_state   <= ST_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_baud_last) begin
            r_baud <= {L_BAUD_W{1'b0}};
            if (r_bit_cnt == L_DATA_LAST) begin
              r_bit_cnt <= 4'd0;
              if (P_PARITY != UART_PAR_NONE) begin
                r_tx    <= r_par;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              // Next bit is shift[1] before the shift takes effect.
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        ST_PARITY: begin
          if (w_baud_last) begin
            r_baud    <= {L_BAUD_W{1'b0}};
            r_bit_cnt <= 4'd0;
            r_tx      <= 1'b1;
            r_state   <= ST_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_baud_last) begin
            r_baud <= {L_BAUD_W{1'b0}};
            if (r_bit_cnt == L_STOP_LAST) begin
              r_bit_cnt <= 4'd0;
              if (w_pop) begin
                r_shift <= w_head;
                r_par   <= uart_parity_bit(UART_DATA_W_MAX'(w_head), P_PARITY);
                r_tx    <= 1'b0;
                r_state <= ST_START;
              end else begin
                r_tx    <= 1'b1;
                r_state <= ST_IDLE;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_baud    <= {L_BAUD_W{1'b0}};
          r_bit_cnt <= 4'd0;
          r_tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule
